// File: rtl/zk_rom_arbiter_pkg.sv
// Shared ZkROM geometry, tag record and glyph-code mapping for the svga text renderers and the ROM arbiter.
// Pure declarations: no latency, no flow control.
package zk_rom_arbiter_pkg;

  localparam int ZK_ADDR_W  = 9;
  localparam int ZK_DATA_W  = 8;
  localparam int ZK_ROM_LAT = 1;
  localparam int ZK_MAX_REQ = 8;
  localparam int TAG_ID_W   = 3;

  localparam logic [4:0] GLYPH_BLANK = 5'd19;
  localparam logic [4:0] GLYPH_SEP   = 5'd27;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Digits 6-9 live after the letter block in the ROM, hence the jump to 21.
  function automatic logic [4:0] glyph_code(input logic [3:0] sym);
    if (sym <= 4'd5)
      return {1'b0, sym};
    else if (sym <= 4'd9)
      return 5'(sym) + 5'd15;
    else if (sym == 4'd10)
      return GLYPH_SEP;
    else
      return GLYPH_BLANK;
  endfunction

  function automatic logic [ZK_ADDR_W-1:0] zk_addr(input logic [4:0] zk, input logic [3:0] row);
    return {zk, row};
  endfunction

endpackage

// File: rtl/zk_rom_arbiter_rr_pick.sv
// Round-robin picker: first eligible index at or after ptr, wrapping at N-1.
// Combinational, no state; the caller owns the pointer and any backpressure.
module zk_rom_arbiter_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 hit
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    hit    = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!hit && elig[j]) begin
        hit       = 1'b1;
        idx       = $clog2(N)'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zk_rom_arbiter.sv
// Round-robin share of the single ZkROM between text renderers; one grant per clock, rows routed back by tag.
// gnt one cycle after req, rsp ROM_LAT+1 cycles after gnt; req is held (level) until its gnt pulse.
module zk_rom_arbiter
  import zk_rom_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = ZK_ADDR_W,
  parameter int DATA_W  = ZK_DATA_W,
  parameter int ROM_LAT = ZK_ROM_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_dout,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_hit;
  logic [IW-1:0]    rr_ptr;

  // Stage 0 pairs with rom_addr, the remaining ROM_LAT stages track the ROM read.
  tag_t tag_q [ROM_LAT+1];

  // A requester still holding req in its own grant cycle sits out one edge.
  assign elig = req & ~gnt;

  zk_rom_arbiter_rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .elig   (elig),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .hit    (pick_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      rom_addr  <= '0;
      rr_ptr    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int s = 0; s <= ROM_LAT; s++)
        tag_q[s] <= '0;
    end else begin
      gnt      <= pick_oh;
      tag_q[0] <= '{vld: pick_hit, id: TAG_ID_W'(pick_idx)};
      if (pick_hit) begin
        rom_addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
        rr_ptr   <= (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
      end
      for (int s = 1; s <= ROM_LAT; s++)
        tag_q[s] <= tag_q[s-1];
      if (tag_q[ROM_LAT].vld) begin
        rsp_valid <= N_REQ'(1) << tag_q[ROM_LAT].id;
        rsp_data  <= rom_dout;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_zk_rom_arbiter.sv
// Bench for zk_rom_arbiter: directed vector table, then randomized traffic against a queue-based reference model.
module tb_zk_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [AW-1:0]   a [N];
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_dout = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_addr
    assign req_addr[g*AW +: AW] = a[g];
  end

  // ROM model: one-clock synchronous read returning the low address byte.
  always @(posedge clk) rom_dout <= rom_addr[7:0];

  zk_rom_arbiter #(
    .N_REQ   (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ROM_LAT (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pointer search over requesters, responses via a 2-deep delay queue.
  typedef struct {
    int          id;
    logic [7:0]  d;
  } pend_t;

  pend_t         pipe [$];
  pend_t         m_p;
  int            m_ptr;
  int            m_w;
  logic [N-1:0]  m_gnt;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  m_rv;
  logic [DW-1:0] m_rd;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ptr  = 0;
      m_gnt  = '0;
      m_addr = '0;
      m_rv   = '0;
      m_rd   = '0;
      pipe   = {};
      pipe.push_back('{-1, 8'h00});
      pipe.push_back('{-1, 8'h00});
    end else begin
      m_p = pipe.pop_front();
      if (m_p.id >= 0) begin
        m_rv = 4'(1 << m_p.id);
        m_rd = m_p.d;
      end else begin
        m_rv = '0;
      end
      m_w = -1;
      for (int k = 0; k < N; k++)
        if (m_w < 0 && req[(m_ptr+k)%N] && !m_gnt[(m_ptr+k)%N])
          m_w = (m_ptr + k) % N;
      if (m_w >= 0) begin
        m_gnt  = 4'(1 << m_w);
        m_addr = a[m_w];
        m_ptr  = (m_w + 1) % N;
        pipe.push_back('{m_w, a[m_w][7:0]});
      end else begin
        m_gnt = '0;
        pipe.push_back('{-1, 8'h00});
      end
    end
  end

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [8:0] addr;
    logic [3:0] rv;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input bit r, input logic [3:0] q, input logic [3:0] g,
                     input logic [8:0] ad, input logic [3:0] v, input logic [7:0] d);
    tbl.push_back('{r, q, g, ad, v, d});
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    a[0]  = 9'h011;
    a[1]  = 9'h122;
    a[2]  = 9'h0A3;
    a[3]  = 9'h1B4;

    //  rst  req      gnt      rom_addr rsp_valid rsp_data
    add(0, 4'b1111, 4'b0000, 9'h000, 4'b0000, 8'h00);  // held in reset
    add(0, 4'b1111, 4'b0000, 9'h000, 4'b0000, 8'h00);
    add(1, 4'b1111, 4'b0001, 9'h011, 4'b0000, 8'h00);  // first grant to 0
    add(1, 4'b0000, 4'b0000, 9'h011, 4'b0000, 8'h00);
    add(1, 4'b0000, 4'b0000, 9'h011, 4'b0001, 8'h11);
    add(1, 4'b0100, 4'b0100, 9'h0A3, 4'b0000, 8'h11);  // single requester 2
    add(1, 4'b0100, 4'b0000, 9'h0A3, 4'b0000, 8'h11);  // no regrant in gnt cycle
    add(1, 4'b0100, 4'b0100, 9'h0A3, 4'b0100, 8'hA3);
    add(1, 4'b0000, 4'b0000, 9'h0A3, 4'b0000, 8'hA3);
    add(1, 4'b1001, 4'b1000, 9'h1B4, 4'b0100, 8'hA3);  // ptr=3: 3,0,3,0
    add(1, 4'b1001, 4'b0001, 9'h011, 4'b0000, 8'hA3);
    add(1, 4'b1001, 4'b1000, 9'h1B4, 4'b1000, 8'hB4);
    add(1, 4'b1001, 4'b0001, 9'h011, 4'b0001, 8'h11);
    add(1, 4'b0000, 4'b0000, 9'h011, 4'b1000, 8'hB4);
    add(1, 4'b0000, 4'b0000, 9'h011, 4'b0001, 8'h11);
    add(1, 4'b0000, 4'b0000, 9'h011, 4'b0000, 8'h11);
    add(1, 4'b1000, 4'b1000, 9'h1B4, 4'b0000, 8'h11);
    add(1, 4'b0011, 4'b0001, 9'h011, 4'b0000, 8'h11);  // req1 loses to 0
    add(1, 4'b0000, 4'b0000, 9'h011, 4'b1000, 8'hB4);  // req1 withdrawn
    add(1, 4'b0000, 4'b0000, 9'h011, 4'b0001, 8'h11);
    add(1, 4'b0000, 4'b0000, 9'h011, 4'b0000, 8'h11);
    add(1, 4'b1111, 4'b0010, 9'h122, 4'b0000, 8'h11);
    add(1, 4'b1111, 4'b0100, 9'h0A3, 4'b0000, 8'h11);  // two in flight
    add(0, 4'b0000, 4'b0000, 9'h000, 4'b0000, 8'h00);  // reset mid-flight
    add(1, 4'b0000, 4'b0000, 9'h000, 4'b0000, 8'h00);
    add(1, 4'b0000, 4'b0000, 9'h000, 4'b0000, 8'h00);
    add(1, 4'b1010, 4'b0010, 9'h122, 4'b0000, 8'h00);  // ptr back at 0
    add(1, 4'b0000, 4'b0000, 9'h122, 4'b0000, 8'h00);
    add(1, 4'b0000, 4'b0000, 9'h122, 4'b0010, 8'h22);

    foreach (tbl[k]) begin
      rst_n = tbl[k].rst;
      req   = tbl[k].req;
      @(negedge clk);
      chk($sformatf("row%0d gnt", k),       32'(gnt),       32'(tbl[k].gnt));
      chk($sformatf("row%0d rom_addr", k),  32'(rom_addr),  32'(tbl[k].addr));
      chk($sformatf("row%0d rsp_valid", k), 32'(rsp_valid), 32'(tbl[k].rv));
      chk($sformatf("row%0d rsp_data", k),  32'(rsp_data),  32'(tbl[k].rd));
    end

    // Randomized traffic with one reset pulse in the middle.
    for (int c = 0; c < 600; c++) begin
      rst_n = !(c == 0 || c == 300 || c == 301);
      for (int i = 0; i < N; i++) begin
        if (req[i] && m_gnt[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(19, 0) == 0) req[i] = 1'b0;
        end else if ($urandom_range(9, 0) < 4) begin
          req[i] = 1'b1;
          a[i]   = AW'($urandom);
        end
      end
      @(negedge clk);
      chk($sformatf("rnd%0d gnt", c),       32'(gnt),       32'(m_gnt));
      chk($sformatf("rnd%0d rom_addr", c),  32'(rom_addr),  32'(m_addr));
      chk($sformatf("rnd%0d rsp_valid", c), 32'(rsp_valid), 32'(m_rv));
      chk($sformatf("rnd%0d rsp_data", c),  32'(rsp_data),  32'(m_rd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/zk_rom_arbiter.md
Name: zk_rom_arbiter

Overview:
- Shares the single synchronous character-glyph ROM (ZkROM, 8-bit row per address) between several on-screen text/number renderers: step counter, expected-step counter, level title, status text.
- Each renderer issues {glyph code, row} fetch requests. The arbiter grants one request per clock, round-robin, drives the ROM address, and routes the returned row back to the owning renderer with a one-hot valid.
- Sits between the svga text renderers and the one ZkROM instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 9, ROM address width ({zk[4:0], row[3:0]})
- DATA_W, 8, glyph row width
- ROM_LAT, 1, ROM read latency in clocks, measured from registered rom_addr to valid rom_dout (1..3)

Ports:
- clk  in  1  system/pixel clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester fetch request, level; held until granted
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i = [i*ADDR_W +: ADDR_W]; must be stable while req[i]=1
- gnt  out  N_REQ  one-hot registered grant pulse, one cycle per accepted request
- rom_addr  out  ADDR_W  registered address to ZkROM
- rom_dout  in  DATA_W  ZkROM data output
- rsp_valid  out  N_REQ  one-hot registered, marks rsp_data for requester i
- rsp_data  out  DATA_W  registered glyph row

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets: gnt=0, rsp_valid=0, rsp_data=0, rom_addr=0, rr_ptr=0, tag pipeline cleared.
- Eligible set: elig[i] = req[i] & ~gnt[i]. A requester holding req during its own gnt cycle is not granted again, so there is no double grant. Max rate per requester is one grant per 2 cycles; different requesters may be granted back to back.
- Arbitration, each edge: search elig starting at index rr_ptr, ascending, wrapping at N_REQ-1 -> 0. First hit w gives:
  - gnt <= onehot(w)
  - rom_addr <= req_addr slice w
  - rr_ptr <= (w+1) mod N_REQ
  - tag stage 0 <= {1, w}
- No hit: gnt <= 0, rom_addr holds its previous value, rr_ptr unchanged, tag stage 0 <= {0, x}.
- Tag pipeline is ROM_LAT+1 stages deep (one stage for the address register, ROM_LAT stages for the ROM). At the output stage, rsp_data <= rom_dout and rsp_valid <= onehot(tag id) if the tag is valid, else 0. rsp_data holds its previous value when no response is issued.
- Latency: req sampled at edge E gives gnt high after E. rsp_valid/rsp_data are high after edge E+ROM_LAT+1, i.e. 2 cycles after gnt for ROM_LAT=1.
- Throughput: one response per clock with ≥2 active requesters. Responses return in grant order; no reordering.
- Fairness: a continuously requesting requester waits at most N_REQ-1 grants.
- A req dropped before grant is legal: the request is withdrawn and no response is issued.
- Reset mid-operation: in-flight tags are discarded and no rsp_valid pulses after reset release until new grants flow through.
- rr_ptr wraps mod N_REQ. For non-power-of-two N_REQ, values ≥ N_REQ are never reached.

Decomposition:
- Shared svga package holds ZK_ADDR_W=9, ZK_DATA_W=8, ZK_ROM_LAT=1, and glyph-code constants (digits 0-5 -> 0-5, 6-9 -> 21-24, blank=19, separator=27), so renderers and the arbiter agree.
- Sub-module rr_pick: combinational round-robin priority picker (elig, ptr -> onehot, index, hit). This is the only natural split; the tag pipeline stays inline.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt, rsp_valid, rom_addr, rsp_data all 0. After release, first grant goes to requester 0.
- Single requester: req[2]=1, addr=9'h0A3, ROM model returns addr[7:0] -> gnt=4'b0100 one cycle; rom_addr=0A3; 2 cycles later rsp_valid=4'b0100, rsp_data=8'hA3. With req held, the next grant comes 2 cycles after the first.
- All four requesting continuously with distinct addresses -> grants 0,1,2,3,0,1,... one per clock; each rsp_valid matches its requester's address 2 cycles after gnt.
- rr_ptr=3 with req=4'b1001 -> grant 3, then 0, then 3. Requester 0 is never starved.
- req[1] asserted, then dropped the cycle before it would win -> no gnt[1], no rsp_valid[1].
- rst_n pulsed low while 2 responses are in flight -> no rsp_valid after release until new requests arrive. rr_ptr restarts at 0.
